// File: rtl/leaf_arb_pkg.sv
// leaf_arb_pkg: shared types and round-robin helper for the leaf output arbiter
package leaf_arb_pkg;
  localparam int DEF_PAYLOAD_BITS = 32;
  localparam int MAX_REQ = 8;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;
  // Lowest offset from ptr wins, so iterate downward and let the last hit stand.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] eligible, input logic [2:0] ptr, input int n);
    rr_pick = ptr;
    for (int k = MAX_REQ - 1; k >= 0; k--)
      if (k < n && eligible[(int'(ptr) + k) % n]) rr_pick = 3'((int'(ptr) + k) % n);
  endfunction
endpackage

// File: rtl/leaf_out_arbiter_rr_picker.sv
// rr_picker: first eligible index at or after ptr, wrapping at NUM_REQ-1
module rr_picker
  import leaf_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int REQ_BITS = 2
) (
  input  logic [NUM_REQ-1:0]  eligible,
  input  logic [REQ_BITS-1:0] ptr,
  output logic [REQ_BITS-1:0] pick
);
  always_comb pick = REQ_BITS'(rr_pick(MAX_REQ'(eligible), 3'(ptr), NUM_REQ));
endmodule

// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: round-robin burst scheduler of NUM_REQ streams onto one vld/ack port
module leaf_out_arbiter
  import leaf_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS,
  parameter int MAX_BURST = 16,
  parameter int REQ_BITS = 2
) (
  input  logic                            clk_user,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              en_mask,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_din,
  input  logic [NUM_REQ-1:0]              req_vld,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [PAYLOAD_BITS-1:0]         dout,
  output logic                            dout_vld,
  input  logic                            dout_ack,
  output logic [REQ_BITS-1:0]             grant_idx,
  output logic                            busy,
  output logic [31:0]                     word_cnt
);
  state_t state;
  logic [REQ_BITS-1:0] rr_ptr, pick;
  logic [8:0] burst_cnt;
  logic out_valid;
  logic [PAYLOAD_BITS-1:0] out_data, g_din;
  logic [NUM_REQ-1:0] eligible;
  logic can_load, accept, g_vld, g_en, last;
  rr_picker #(.NUM_REQ(NUM_REQ), .REQ_BITS(REQ_BITS)) u_pick (
    .eligible(eligible),
    .ptr(rr_ptr),
    .pick(pick)
  );
  // Accept is gated by reset so a word landing on the reset edge is never acked.
  always_comb begin
    eligible = req_vld & en_mask;
    g_vld = req_vld[grant_idx];
    g_en = en_mask[grant_idx];
    g_din = req_din[grant_idx*PAYLOAD_BITS +: PAYLOAD_BITS];
    can_load = !out_valid || dout_ack;
    accept = reset && state == BURST && can_load && g_vld && g_en;
    last = burst_cnt == 9'(MAX_BURST - 1);
    req_ack = accept ? NUM_REQ'(1) << grant_idx : '0;
  end
  assign dout = out_data;
  assign dout_vld = out_valid;
  assign busy = state == BURST;
  always_ff @(posedge clk_user) begin
    if (!reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_idx <= '0;
      burst_cnt <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      word_cnt <= '0;
    end else begin
      if (out_valid && dout_ack) word_cnt <= word_cnt + 32'd1;
      if (accept) begin
        out_valid <= 1'b1;
        out_data <= g_din;
        burst_cnt <= burst_cnt + 9'd1;
      end else if (dout_ack) out_valid <= 1'b0;
      if (state == IDLE) begin
        if (|eligible) begin
          grant_idx <= pick;
          burst_cnt <= '0;
          state <= BURST;
        end
      end else if (!g_vld || !g_en || (accept && last)) begin
        state <= IDLE;
        rr_ptr <= grant_idx == REQ_BITS'(NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb_leaf_out_arbiter: directed checks of arbitration, bursts, backpressure, masking and reset
module tb_leaf_out_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clk_user = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] en_mask = '1;
  logic [N*W-1:0] req_din = '0;
  logic [N-1:0] req_vld = '0;
  logic [N-1:0] req_ack;
  logic [W-1:0] dout;
  logic dout_vld;
  logic dout_ack = 1'b1;
  logic [1:0] grant_idx;
  logic busy;
  logic [31:0] word_cnt;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] nxt[N];
  int rem[N];
  logic [N-1:0] ack_s;
  logic [31:0] obs_w[$];
  int obs_t[$];
  logic [31:0] held, saved;
  int bad;

  leaf_out_arbiter dut (
    .clk_user(clk_user), .reset(reset), .en_mask(en_mask), .req_din(req_din),
    .req_vld(req_vld), .req_ack(req_ack), .dout(dout), .dout_vld(dout_vld),
    .dout_ack(dout_ack), .grant_idx(grant_idx), .busy(busy), .word_cnt(word_cnt)
  );

  always #5 clk_user = ~clk_user;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_vld[i] = rem[i] > 0;
      req_din[i*W +: W] = nxt[i];
    end
  endtask

  // Requesters advance only on a sampled ack; dout transfers are logged with their cycle.
  task automatic step();
    @(negedge clk_user);
    ack_s = req_ack;
    if (dout_vld && dout_ack) begin
      obs_w.push_back(dout);
      obs_t.push_back(cyc);
    end
    @(posedge clk_user);
    #1;
    cyc++;
    for (int i = 0; i < N; i++)
      if (ack_s[i] && req_vld[i]) begin
        nxt[i]++;
        rem[i]--;
      end
    drive();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic restart();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      nxt[i] = 0;
    end
    drive();
    reset = 1'b0;
    step();
    reset = 1'b1;
    obs_w.delete();
    obs_t.delete();
  endtask

  initial begin
    req_vld = '1;
    repeat (3) begin
      @(posedge clk_user);
      #2;
      chk("rst_dout_vld", dout_vld, 0);
      chk("rst_req_ack", req_ack, 0);
      chk("rst_word_cnt", word_cnt, 0);
      chk("rst_grant", grant_idx, 0);
    end

    restart();
    rem[2] = 20;
    nxt[2] = 32'h100;
    drive();
    run(30);
    chk("single_count", obs_w.size(), 20);
    for (int k = 0; k < 20; k++) chk("single_word", obs_w[k], 32'h100 + k);
    chk("single_burst_len", 32'(obs_t[15] - obs_t[0]), 15);
    chk("single_gap", 32'(obs_t[16] - obs_t[15]), 2);
    chk("single_word_cnt", word_cnt, 20);

    restart();
    for (int i = 0; i < N; i++) begin
      rem[i] = 1000;
      nxt[i] = 32'(i + 1) << 12;
    end
    drive();
    run(95);
    chk("rr_enough", 32'(obs_w.size() >= 80), 1);
    for (int r = 0; r < 5; r++) begin
      chk("rr_run_first", obs_w[16*r], (32'((r % 4) + 1) << 12) + 32'(16 * (r / 4)));
      if (r > 0) chk("rr_period", 32'(obs_t[16*r] - obs_t[16*r-16]), 17);
    end
    bad = 0;
    for (int k = 1; k < 80; k++)
      if (k % 16 != 0 && obs_w[k] !== obs_w[k-1] + 1) bad++;
    chk("rr_contiguous", bad, 0);

    restart();
    rem[0] = 20;
    nxt[0] = 32'h200;
    drive();
    run(5);
    dout_ack = 1'b0;
    #1;
    held = dout;
    chk("bp_held_vld", dout_vld, 1);
    repeat (5) begin
      chk("bp_req_ack", req_ack, 0);
      chk("bp_dout", dout, held);
      chk("bp_grant", grant_idx, 0);
      step();
    end
    dout_ack = 1'b1;
    run(30);
    chk("bp_count", obs_w.size(), 20);
    bad = 0;
    for (int k = 0; k < 20; k++) if (obs_w[k] !== 32'h200 + k) bad++;
    chk("bp_sequence", bad, 0);
    chk("bp_gap", 32'(obs_t[16] - obs_t[15]), 2);

    restart();
    rem[1] = 3;
    nxt[1] = 32'h300;
    rem[2] = 50;
    nxt[2] = 32'h400;
    drive();
    run(12);
    chk("early_w0", obs_w[0], 32'h300);
    chk("early_w2", obs_w[2], 32'h302);
    chk("early_next", obs_w[3], 32'h400);
    chk("early_grant", grant_idx, 2);
    en_mask = 4'b1011;
    #1;
    chk("mask_no_ack", req_ack, 0);
    chk("mask_busy_now", busy, 1);
    step();
    chk("mask_released", busy, 0);
    saved = nxt[2];
    run(10);
    chk("mask_no_grant", nxt[2], saved);
    chk("mask_idle", busy, 0);
    en_mask = 4'b1111;
    step();
    chk("unmask_grant", grant_idx, 2);
    chk("unmask_busy", busy, 1);
    run(5);
    chk("unmask_words", nxt[2], saved + 5);

    restart();
    rem[1] = 2;
    nxt[1] = 32'h500;
    rem[2] = 50;
    nxt[2] = 32'h600;
    drive();
    run(10);
    chk("mid_vld", dout_vld, 1);
    chk("mid_dout", dout, 32'h604);
    rem[0] = 50;
    nxt[0] = 32'h700;
    drive();
    reset = 1'b0;
    #1;
    chk("mid_rst_no_ack", req_ack, 0);
    step();
    reset = 1'b1;
    chk("mid_rst_vld", dout_vld, 0);
    chk("mid_rst_cnt", word_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    step();
    chk("mid_regrant", grant_idx, 0);
    chk("mid_regrant_busy", busy, 1);
    run(2);
    chk("mid_first_word", obs_w[obs_w.size()-1], 32'h700);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/leaf_out_arbiter.md
Name: leaf_out_arbiter

Overview:
- Round-robin scheduler sharing one leaf_interface user-to-interface port (32-bit payload, vld/ack handshake) among NUM_REQ HLS-generated output streams in one leaf.
- Grants one requester for a bounded burst, then rotates.
- Sits between the user kernel instances and din_leaf_user2interface / vld_user2interface / ack_interface2user of leaf_interface, on the user clock.

Parameters:
- NUM_REQ, 4, number of requester streams (2..8).
- PAYLOAD_BITS, 32, data width per word.
- MAX_BURST, 16, maximum words accepted per grant (1..256).
- REQ_BITS, 2, width of the grant index (ceil(log2(NUM_REQ))).

Ports:
- clk_user  in  1  user clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- en_mask  in  NUM_REQ  per-requester enable; bit clear = never granted.
- req_din  in  NUM_REQ*PAYLOAD_BITS  requester payloads; requester i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- req_vld  in  NUM_REQ  requester word valid.
- req_ack  out  NUM_REQ  word accepted from requester i.
- dout  out  PAYLOAD_BITS  word to leaf_interface.
- dout_vld  out  1  dout valid.
- dout_ack  in  1  leaf_interface accepted dout.
- grant_idx  out  REQ_BITS  currently granted requester.
- busy  out  1  high in state BURST.
- word_cnt  out  32  total words forwarded since reset; wraps at 2^32.

Behaviour:
- Transfer rule: a word moves on any cycle where vld and ack are both high on the same side.
- vld, once high, is held with stable data until acked.
- Reset (reset==0 at a clock edge):
  - state=IDLE, rr_ptr=0, grant_idx=0, burst_cnt=0.
  - out_valid=0, dout=0, dout_vld=0, req_ack=0, busy=0, word_cnt=0.
  - Reset asserted mid-burst drops the output register contents without acking anything further.
  - Requesters must re-present the dropped word.
- Output stage: one pipeline register (out_valid, out_data).
  - dout = out_data and dout_vld = out_valid, both registered.
  - can_load = !out_valid | dout_ack (combinational).
- States:
  - IDLE:
    - Eligible set = req_vld & en_mask.
    - If non-empty, pick the first eligible index at or after rr_ptr, searching upward with wrap NUM_REQ-1 -> 0.
    - Register it into grant_idx, set burst_cnt=0, go to BURST. No word is accepted in the IDLE cycle.
    - If the set is empty, stay in IDLE.
  - BURST:
    - req_ack[grant_idx] = can_load & req_vld[grant_idx] & en_mask[grant_idx]. All other req_ack bits are 0.
    - On accept: out_data <= req_din slice, out_valid <= 1, burst_cnt++.
    - Release to IDLE at the end of a cycle when any of these holds:
      - (a) an accept makes burst_cnt reach MAX_BURST;
      - (b) req_vld[grant_idx]==0;
      - (c) en_mask[grant_idx]==0.
    - On release, rr_ptr <= grant_idx+1 (mod NUM_REQ).
- Output register update:
  - If dout_ack and no load in the same cycle, out_valid <= 0.
  - A simultaneous drain and load keeps out_valid=1 with the new data: full throughput of 1 word/cycle during a burst.
- word_cnt increments on each dout_vld & dout_ack.
- Latency: requester accept -> dout_vld is 1 cycle.
- Burst overhead: 1 idle arbitration cycle per grant.
- Fairness: each requester with vld held waits at most (NUM_REQ-1)*(MAX_BURST+1) accepted-or-stalled grant slots.
- Backpressure: dout_ack low with out_valid=1 means no req_ack. The grant is held and burst_cnt frozen; no timeout.
- en_mask changes take effect in the next arbitration. Clearing the bit of the granted requester ends the burst (no ack that cycle).
- MAX_BURST=1 gives a pure per-word round-robin with alternating arbitrate/accept cycles.

Decomposition:
- Shared package leaf_arb_pkg:
  - state encoding (IDLE=1'b0, BURST=1'b1);
  - function rr_pick(eligible, ptr) returning the next index;
  - PAYLOAD_BITS default constant shared with leaf_interface.
- Sub-module rr_picker (combinational priority rotate) is natural; it is instantiated once.
- The output register stays inline.

Test Plan:
- Reset hold: reset=0 for 3 cycles with all req_vld=1 -> dout_vld=0, req_ack=0, word_cnt=0, grant_idx=0 throughout.
- Single requester: en_mask=4'b1111, req 2 streams 20 words 0x100..0x113, dout_ack=1 -> words 0x100..0x10F, one idle cycle, then 0x110..0x113; word_cnt=20.
- Round-robin: all 4 requesters continuously valid, MAX_BURST=16 -> grant order 0,1,2,3,0, exactly 16 words each, 17-cycle period per grant.
- Backpressure: dout_ack=0 for 5 cycles mid-burst -> dout holds its value, req_ack=0, burst_cnt unchanged; on release, data continues with no loss or duplication.
- Early release and mask: req 1 drops vld after 3 words -> grant moves to 2 next arbitration. en_mask[2] cleared mid-burst -> burst ends; requester 2 is not granted until re-enabled.
- Reset mid-burst: reset=0 pulsed after 5 words with out_valid=1 -> dout_vld=0 the next cycle, grant restarts from requester 0.
